// File: rtl/user_rom.sv
// Read-only OBI slave exposing an ID/version/pattern ROM in a 4 KiB window.
// Reads return content after ReadLatency cycles; writes and out-of-range reads return err.
module user_rom #(
    parameter int unsigned NumWords    = 16,
    parameter int unsigned ReadLatency = 1,
    parameter logic [31:0] MagicId     = 32'hC0DE_0001,
    parameter logic [31:0] Version     = 32'h0001_0000,
    parameter int unsigned IdWidth     = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        wdata_i,
    input  logic [IdWidth-1:0] aid_i,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic               err_o,
    output logic [IdWidth-1:0] rid_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Extra WAIT cycles beyond the first; only meaningful when ReadLatency >= 2.
    localparam logic [2:0] CntLoad = (ReadLatency >= 2) ? 3'(ReadLatency - 2) : 3'd0;

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [9:0]           idx_q;
    logic                 we_q;
    logic [IdWidth-1:0]   aid_q;

    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [IdWidth-1:0]   rid_q, rid_d;

    logic                 handshake;
    logic [9:0]           idx_in;
    logic                 load_resp;
    logic [9:0]           src_idx;
    logic                 src_we;
    logic [IdWidth-1:0]   src_aid;
    logic                 src_in_range;

    logic                 unused_inputs;
    assign unused_inputs = ^{be_i, wdata_i, addr_i[31:12], addr_i[1:0]};

    assign idx_in    = addr_i[11:2];
    assign gnt_o     = (state_q != StWait);
    assign handshake = req_i & gnt_o;

    function automatic logic [31:0] word_content(input logic [9:0] idx);
        logic [31:0] data;
        if (idx == 10'd0) begin
            data = MagicId;
        end else if (idx == 10'd1) begin
            data = Version;
        end else begin
            data = {16'hC0DE, 6'd0, idx};
        end
        return data;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_resp = 1'b0;
        src_idx   = idx_q;
        src_we    = we_q;
        src_aid   = aid_q;

        unique case (state_q)
            StIdle, StResp: begin
                if (handshake) begin
                    if (ReadLatency == 1) begin
                        state_d   = StResp;
                        load_resp = 1'b1;
                        src_idx   = idx_in;
                        src_we    = we_i;
                        src_aid   = aid_i;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d   = StResp;
                    load_resp = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign src_in_range = ({22'd0, src_idx} < NumWords);

    // Response registers stay zero except in the single RESP cycle.
    always_comb begin
        rvalid_d = load_resp;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
        rid_d    = '0;
        if (load_resp) begin
            rid_d = src_aid;
            if (src_we || !src_in_range) begin
                err_d = 1'b1;
            end else begin
                rdata_d = word_content(src_idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            idx_q    <= 10'd0;
            we_q     <= 1'b0;
            aid_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rid_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rid_q    <= rid_d;
            if (handshake) begin
                idx_q <= idx_in;
                we_q  <= we_i;
                aid_q <= aid_i;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign rid_o    = rid_q;

endmodule
